// File: rtl/oled_power_sequencer.sv
// ============================================================================
// oled_power_sequencer
//
// Power-up / power-down sequencer for the PmodOLEDrgb panel. It drives
// PMODEN, RES# and VCCEN in the order the panel datasheet requires. Between
// reset release and VCC enable it hands control to the init-command sender.
// Each wait is timed by an external microsecond delay timer. The sequencer
// loads a delay into that timer with a one-cycle update strobe and moves on
// when the timer returns its done pulse.
//
// Optional feature (compile-time macro):
//   OLED_INIT_TIMEOUT_EN
//     Defined: a cycle counter runs while waiting for init_ack. If it reaches
//     INIT_TIMEOUT_CYCLES, the sticky fault flag is set and the panel is
//     powered back down to OFF.
//     Undefined: INIT waits indefinitely, fault is tied low and no counter
//     is built.
//
// Ports:
//   clk                 in   system clock
//   rst_n               in   asynchronous active-low reset
//   power_on            in   one-cycle request to start power-up
//   power_off           in   one-cycle request to start power-down
//   timer_update_match  out  one-cycle load strobe to the delay timer
//   timer_match         out  delay in microseconds; valid with the strobe and
//                            held between strobes
//   timer_done          in   one-cycle delay-expired pulse from the timer
//   init_req            out  level; the init command sender may run
//   init_ack            in   one-cycle pulse; init commands are complete
//   pmoden              out  panel logic supply enable
//   res_n               out  panel reset, active low
//   vccen               out  panel high-voltage enable
//   powered             out  sequence complete, panel is on
//   busy                out  high in every state except OFF and ON
//   fault               out  sticky init-timeout flag
// ============================================================================
module oled_power_sequencer #(
    parameter int          CLOCK_COUNT_W       = 32,
    parameter int unsigned DELAY_PMOD_US       = 20000,
    parameter int unsigned DELAY_RES_US        = 3,
    parameter int unsigned DELAY_VCC_US        = 25000,
    parameter int unsigned DELAY_VCCOFF_US     = 400000,
    parameter int unsigned INIT_TIMEOUT_CYCLES = 1048576
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     power_on,
    input  logic                     power_off,
    output logic                     timer_update_match,
    output logic [CLOCK_COUNT_W-1:0] timer_match,
    input  logic                     timer_done,
    output logic                     init_req,
    input  logic                     init_ack,
    output logic                     pmoden,
    output logic                     res_n,
    output logic                     vccen,
    output logic                     powered,
    output logic                     busy,
    output logic                     fault
);

    // ------------------------------------------------------------------
    // Elaboration checks: every delay must fit the timer match bus.
    // Values are never silently truncated.
    // ------------------------------------------------------------------
    if (CLOCK_COUNT_W < 1) begin : g_chk_width
        $error("oled_power_sequencer: CLOCK_COUNT_W must be at least 1");
    end

    if (CLOCK_COUNT_W < 32) begin : g_chk_fit
        if (((DELAY_PMOD_US   >> CLOCK_COUNT_W) != 0) ||
            ((DELAY_RES_US    >> CLOCK_COUNT_W) != 0) ||
            ((DELAY_VCC_US    >> CLOCK_COUNT_W) != 0) ||
            ((DELAY_VCCOFF_US >> CLOCK_COUNT_W) != 0)) begin : g_fail
            $error("oled_power_sequencer: a delay parameter does not fit CLOCK_COUNT_W");
        end
    end

    if (INIT_TIMEOUT_CYCLES < 1) begin : g_chk_timeout
        $error("oled_power_sequencer: INIT_TIMEOUT_CYCLES must be at least 1");
    end

    // A zero load would never produce a done pulse and would stall the
    // sequence. Each delay is therefore clamped to at least one microsecond.
    function automatic logic [CLOCK_COUNT_W-1:0] load_value(input int unsigned delay_us);
        return (delay_us == 0) ? CLOCK_COUNT_W'(1) : CLOCK_COUNT_W'(delay_us);
    endfunction

    localparam logic [CLOCK_COUNT_W-1:0] LOAD_PMOD   = load_value(DELAY_PMOD_US);
    localparam logic [CLOCK_COUNT_W-1:0] LOAD_RES    = load_value(DELAY_RES_US);
    localparam logic [CLOCK_COUNT_W-1:0] LOAD_VCC    = load_value(DELAY_VCC_US);
    localparam logic [CLOCK_COUNT_W-1:0] LOAD_VCCOFF = load_value(DELAY_VCCOFF_US);

    typedef enum logic [2:0] {
        S_OFF         = 3'd0,
        S_PMOD_WAIT   = 3'd1,
        S_RES_LOW     = 3'd2,
        S_RES_HIGH    = 3'd3,
        S_INIT        = 3'd4,
        S_VCC_WAIT    = 3'd5,
        S_ON          = 3'd6,
        S_VCCOFF_WAIT = 3'd7
    } state_t;

    state_t state;

    // power_off before VCC is up needs no discharge wait. The sequencer
    // simply drops the logic supply and returns to OFF.
    logic early_abort;
    assign early_abort = power_off &&
                         ((state == S_PMOD_WAIT) || (state == S_RES_LOW) ||
                          (state == S_RES_HIGH)  || (state == S_INIT));

`ifdef OLED_INIT_TIMEOUT_EN
    localparam int TO_W = (INIT_TIMEOUT_CYCLES > 1) ? $clog2(INIT_TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(INIT_TIMEOUT_CYCLES - 1);

    // Counts the cycles spent in INIT. It is cleared on entry to INIT.
    logic [TO_W-1:0] init_cnt;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_OFF;
            pmoden             <= 1'b0;
            res_n              <= 1'b1;
            vccen              <= 1'b0;
            init_req           <= 1'b0;
            powered            <= 1'b0;
            busy               <= 1'b0;
            timer_update_match <= 1'b0;
            timer_match        <= '0;
`ifdef OLED_INIT_TIMEOUT_EN
            fault              <= 1'b0;
            init_cnt           <= '0;
`endif
        end else begin
            timer_update_match <= 1'b0;

            if (early_abort) begin
                state    <= S_OFF;
                pmoden   <= 1'b0;
                res_n    <= 1'b1;
                init_req <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_OFF: begin
                        // If power_off arrives in the same cycle, it cancels the request.
                        if (power_on && !power_off) begin
                            state              <= S_PMOD_WAIT;
                            pmoden             <= 1'b1;
                            busy               <= 1'b1;
                            timer_update_match <= 1'b1;
                            timer_match        <= LOAD_PMOD;
`ifdef OLED_INIT_TIMEOUT_EN
                            fault              <= 1'b0;
`endif
                        end
                    end

                    S_PMOD_WAIT: begin
                        if (timer_done) begin
                            state              <= S_RES_LOW;
                            res_n              <= 1'b0;
                            timer_update_match <= 1'b1;
                            timer_match        <= LOAD_RES;
                        end
                    end

                    S_RES_LOW: begin
                        if (timer_done) begin
                            state              <= S_RES_HIGH;
                            res_n              <= 1'b1;
                            timer_update_match <= 1'b1;
                            timer_match        <= LOAD_RES;
                        end
                    end

                    S_RES_HIGH: begin
                        if (timer_done) begin
                            state    <= S_INIT;
                            init_req <= 1'b1;
`ifdef OLED_INIT_TIMEOUT_EN
                            init_cnt <= '0;
`endif
                        end
                    end

                    S_INIT: begin
                        if (init_ack) begin
                            state              <= S_VCC_WAIT;
                            init_req           <= 1'b0;
                            vccen              <= 1'b1;
                            timer_update_match <= 1'b1;
                            timer_match        <= LOAD_VCC;
                        end
`ifdef OLED_INIT_TIMEOUT_EN
                        else if (init_cnt == TO_LAST) begin
                            state    <= S_OFF;
                            init_req <= 1'b0;
                            pmoden   <= 1'b0;
                            busy     <= 1'b0;
                            fault    <= 1'b1;
                        end else begin
                            init_cnt <= init_cnt + 1'b1;
                        end
`endif
                    end

                    S_VCC_WAIT: begin
                        // VCC is already up, so power-down must wait for the discharge delay.
                        if (power_off) begin
                            state              <= S_VCCOFF_WAIT;
                            vccen              <= 1'b0;
                            timer_update_match <= 1'b1;
                            timer_match        <= LOAD_VCCOFF;
                        end else if (timer_done) begin
                            state   <= S_ON;
                            powered <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end

                    S_ON: begin
                        if (power_off) begin
                            state              <= S_VCCOFF_WAIT;
                            powered            <= 1'b0;
                            vccen              <= 1'b0;
                            busy               <= 1'b1;
                            timer_update_match <= 1'b1;
                            timer_match        <= LOAD_VCCOFF;
                        end
                    end

                    S_VCCOFF_WAIT: begin
                        if (timer_done) begin
                            state  <= S_OFF;
                            pmoden <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end

                    default: begin
                        state    <= S_OFF;
                        pmoden   <= 1'b0;
                        res_n    <= 1'b1;
                        vccen    <= 1'b0;
                        init_req <= 1'b0;
                        powered  <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oled_power_sequencer.sv
module tb_oled_power_sequencer;

    localparam int W  = 32;
    localparam int P  = 5;     // DELAY_PMOD_US
    localparam int R  = 2;     // DELAY_RES_US
    localparam int V  = 3;     // DELAY_VCC_US
    localparam int VO = 10;    // DELAY_VCCOFF_US
    localparam int TO = 100;   // INIT_TIMEOUT_CYCLES
    localparam int U  = 4;     // clock cycles per microsecond in the timer model

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- main DUT ----------------
    logic power_on = 1'b0, power_off = 1'b0, init_ack = 1'b0, xdone = 1'b0;
    logic timer_update_match, timer_done, init_req;
    logic [W-1:0] timer_match;
    logic pmoden, res_n, vccen, powered, busy, fault;

    oled_power_sequencer #(
        .CLOCK_COUNT_W(W), .DELAY_PMOD_US(P), .DELAY_RES_US(R),
        .DELAY_VCC_US(V), .DELAY_VCCOFF_US(VO), .INIT_TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .power_on(power_on), .power_off(power_off),
        .timer_update_match(timer_update_match), .timer_match(timer_match),
        .timer_done(timer_done), .init_req(init_req), .init_ack(init_ack),
        .pmoden(pmoden), .res_n(res_n), .vccen(vccen), .powered(powered),
        .busy(busy), .fault(fault)
    );

    // Behavioural microsecond timer: a load of N microseconds produces one
    // done pulse N*U cycles later. A zero load never fires.
    int   tcnt;
    logic tdone;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= 0; tdone <= 1'b0;
        end else if (timer_update_match) begin
            tcnt <= int'(timer_match) * U; tdone <= 1'b0;
        end else if (tcnt != 0) begin
            tcnt <= tcnt - 1; tdone <= (tcnt == 1);
        end else begin
            tdone <= 1'b0;
        end
    end
    assign timer_done = tdone | xdone;

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int         c;
        logic [6:0] pins;
        logic       stb;
        logic [31:0] m;
    } ev_t;
    ev_t q[$];

    bit m_pmod = 0, m_res = 1, m_vcc = 0, m_req = 0, m_pwr = 0, m_busy = 0, m_fault = 0;
    logic [31:0] m_last = 0;
    localparam logic [6:0] RESET_PINS = 7'b0100000;

    function automatic logic [6:0] mpins();
        return {m_pmod, m_res, m_vcc, m_req, m_pwr, m_busy, m_fault};
    endfunction

    task automatic expect_ev(input int c, input logic stb, input logic [31:0] m);
        ev_t e;
        if (stb) m_last = m;
        e.c = c; e.pins = mpins(); e.stb = stb; e.m = m_last;
        q.push_back(e);
    endtask

    // Monitor: any pin change or load strobe is one DUT output event.
    bit         mon_en = 0;
    logic [6:0] prev_pins = 7'b0100000;
    logic [6:0] mon_cur;
    ev_t        mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_cur = {pmoden, res_n, vccen, init_req, powered, busy, fault};
            if (timer_update_match || (mon_cur != prev_pins)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: cyc=%0d pins=%b stb=%b match=%0d, required no event",
                             cyc, mon_cur, timer_update_match, timer_match);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.c != cyc || mon_e.pins != mon_cur ||
                        mon_e.stb != timer_update_match || mon_e.m != timer_match) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d pins=%b stb=%b match=%0d, required cyc=%0d pins=%b stb=%b match=%0d",
                                 cyc, mon_cur, timer_update_match, timer_match,
                                 mon_e.c, mon_e.pins, mon_e.stb, mon_e.m);
                    end
                end
            end
            prev_pins = mon_cur;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic go(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input bit on, input bit off, input bit ack, input bit xd);
        power_on = on; power_off = off; init_ack = ack; xdone = xd;
        @(posedge clk); #1;
        power_on = 0; power_off = 0; init_ack = 0; xdone = 0;
    endtask

    // power_off before VCC is enabled: OFF on the next cycle, no timer load.
    task automatic do_abort(input int lo, input int hi);
        int d;
        d = lo + int'($urandom_range(0, hi - lo - 2));
        m_pmod = 0; m_res = 1; m_req = 0; m_busy = 0;
        expect_ev(d + 1, 0, 0);
        go(d); pulse(0, 1, 0, 0);
    endtask

    task automatic power_down(input int t);
        int tn, d;
        tn = t + VO * U + 2;
        m_pmod = 0; m_busy = 0;
        expect_ev(tn, 0, 0);
        // power_on and power_off during the discharge wait are both ignored.
        d = t + int'($urandom_range(0, VO * U - 3));
        go(d); pulse(1, 1, 1, 0);
        go(tn);
    endtask

    // One power cycle. abort_stage: 0 none, 1 PMOD_WAIT, 2 RES_LOW,
    // 3 RES_HIGH, 4 INIT.
    task automatic seq(input int abort_stage, input bit early_off, input bit withhold_ack);
        int d, t, tn;
        d = cyc + int'($urandom_range(0, 4));
        m_pmod = 1; m_busy = 1; m_fault = 0;
        expect_ev(d + 1, 1, P);
        go(d); pulse(1, 0, 0, 0);
        t = d + 1;

        tn = t + P * U + 2;
        if (abort_stage == 1) begin do_abort(t, tn); go(tn); return; end
        m_res = 0; expect_ev(tn, 1, R);
        d = t + int'($urandom_range(0, P * U - 1));
        go(d); pulse(0, 0, 1, 0);                 // stray init_ack ignored
        t = tn;

        tn = t + R * U + 2;
        if (abort_stage == 2) begin do_abort(t, tn); go(tn); return; end
        m_res = 1; expect_ev(tn, 1, R);
        t = tn;

        tn = t + R * U + 2;
        if (abort_stage == 3) begin do_abort(t, tn); go(tn); return; end
        m_req = 1; expect_ev(tn, 0, 0);
        t = tn;

        if (withhold_ack) begin
            m_req = 0; m_pmod = 0; m_busy = 0; m_fault = 1;
            expect_ev(t + TO, 0, 0);
            go(t + TO + 1);
            return;
        end
        if (abort_stage == 4) begin do_abort(t, t + 8); go(t + 8); return; end
        d = t + int'($urandom_range(0, 6));
        m_req = 0; m_vcc = 1; expect_ev(d + 1, 1, V);
        go(d); pulse(0, 0, 1, 0);
        t = d + 1;

        tn = t + V * U + 2;
        if (early_off) begin
            d = t + int'($urandom_range(0, V * U));
            m_vcc = 0; expect_ev(d + 1, 1, VO);
            go(d); pulse(0, 1, 0, 0);
            power_down(d + 1);
            return;
        end
        m_pwr = 1; m_busy = 0; expect_ev(tn, 0, 0);
        t = tn;

        go(t); pulse(1, 0, 1, 1);                 // stray on/ack/done in ON ignored
        d = t + 1 + int'($urandom_range(0, 5));
        m_pwr = 0; m_vcc = 0; m_busy = 1; expect_ev(d + 1, 1, VO);
        go(d); pulse(0, 1, 0, 0);
        power_down(d + 1);
    endtask

    // ---------------- second DUT: zero RES delay is clamped to 1 ----------------
    logic po0 = 1'b0, ack0 = 1'b0;
    logic tum0, tdone0, req0, pmoden0, res_n0, vccen0, powered0, busy0, fault0;
    logic [W-1:0] tm0;
    int   tcnt0;
    bit   done0 = 0;
    logic [31:0] mq0[$];
    logic [31:0] m0_exp;

    oled_power_sequencer #(
        .CLOCK_COUNT_W(W), .DELAY_PMOD_US(P), .DELAY_RES_US(0),
        .DELAY_VCC_US(V), .DELAY_VCCOFF_US(VO), .INIT_TIMEOUT_CYCLES(TO)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .power_on(po0), .power_off(1'b0),
        .timer_update_match(tum0), .timer_match(tm0),
        .timer_done(tdone0), .init_req(req0), .init_ack(ack0),
        .pmoden(pmoden0), .res_n(res_n0), .vccen(vccen0), .powered(powered0),
        .busy(busy0), .fault(fault0)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt0 <= 0; tdone0 <= 1'b0;
        end else if (tum0) begin
            tcnt0 <= int'(tm0) * U; tdone0 <= 1'b0;
        end else if (tcnt0 != 0) begin
            tcnt0 <= tcnt0 - 1; tdone0 <= (tcnt0 == 1);
        end else begin
            tdone0 <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && tum0) begin
            checks++;
            if (mq0.size() == 0) begin
                errors++;
                $display("FAIL res0_load: unexpected load of %0d", tm0);
            end else begin
                m0_exp = mq0.pop_front();
                if (tm0 != m0_exp) begin
                    errors++;
                    $display("FAIL res0_load: got %0d, required %0d", tm0, m0_exp);
                end
            end
        end
    end

    initial begin
        @(posedge rst_n);
        @(posedge clk); #1;
        mq0.push_back(P); mq0.push_back(1); mq0.push_back(1); mq0.push_back(V);
        po0 = 1; @(posedge clk); #1; po0 = 0;
        for (int i = 0; i < 500 && !req0; i++) begin @(posedge clk); #1; end
        ack0 = 1; @(posedge clk); #1; ack0 = 0;
        for (int i = 0; i < 500 && !powered0; i++) begin @(posedge clk); #1; end
        checks++;
        if (powered0 !== 1'b1) begin
            errors++;
            $display("FAIL res0_powered: got %b, required 1", powered0);
        end
        checks++;
        if (mq0.size() != 0) begin
            errors++;
            $display("FAIL res0_loads_missing: %0d outstanding, required 0", mq0.size());
        end
        done0 = 1;
    end

    // ---------------- main sequence ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pmoden, res_n, vccen, init_req, powered, busy, fault} !== RESET_PINS ||
            timer_update_match !== 1'b0 || timer_match !== '0) begin
            errors++;
            $display("FAIL reset_state: pins=%b stb=%b match=%0d, required pins=%b stb=0 match=0",
                     {pmoden, res_n, vccen, init_req, powered, busy, fault},
                     timer_update_match, timer_match, RESET_PINS);
        end
        rst_n = 1;
        @(posedge clk); #1;
        mon_en = 1;

        seq(0, 0, 0);                            // full power cycle
        seq(2, 0, 0);                            // power_off in RES_LOW
        go(cyc + 3); pulse(1, 1, 0, 0);          // on+off together in OFF: no effect
        go(cyc + 5); pulse(0, 1, 0, 1);          // power_off and stray done in OFF: no effect
        go(cyc + 5);
        seq(0, 1, 0);                            // power_off during VCC_WAIT
        for (int i = 0; i < 8; i++)
            seq(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 0);
`ifdef OLED_INIT_TIMEOUT_EN
        seq(0, 0, 1);                            // init_ack withheld: timeout fault
        seq(0, 0, 0);                            // next power_on clears fault
`endif

        // Asynchronous reset in the middle of a power-up.
        mon_en = 0;
        pulse(1, 0, 0, 0);
        go(cyc + 6);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({pmoden, res_n, vccen, init_req, powered, busy, fault} !== RESET_PINS ||
            timer_update_match !== 1'b0 || timer_match !== '0) begin
            errors++;
            $display("FAIL async_reset: pins=%b stb=%b match=%0d, required pins=%b stb=0 match=0",
                     {pmoden, res_n, vccen, init_req, powered, busy, fault},
                     timer_update_match, timer_match, RESET_PINS);
        end
        @(posedge clk); #1;
        rst_n = 1;
        m_pmod = 0; m_res = 1; m_vcc = 0; m_req = 0; m_pwr = 0; m_busy = 0; m_fault = 0;
        m_last = 0;
        prev_pins = RESET_PINS;
        @(posedge clk); #1;
        mon_en = 1;
        seq(0, 0, 0);                            // restarts from PMOD_WAIT

        go(cyc + 10);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d outstanding, required 0", q.size());
        end
        for (int i = 0; i < 5000 && !done0; i++) begin @(posedge clk); #1; end
        checks++;
        if (!done0) begin
            errors++;
            $display("FAIL res0_sequence: did not complete, required completion");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
